xor_unit_arbiter: RTL

// - Shares the single wide XOR unit between the AES requester (AddRoundKey/MixColumns operand bundles) and the SHA-3 requester (theta/iota column bundles).
// - Accepts 800-bit operand bundles: 4 lanes x 200 b, each lane = 5 x 40-bit XOR inputs.
// - Drives them to the XOR unit, registers the 160-bit result and routes it back to the owning requester.
// - Supports multi-beat locked bursts so a SHA-3 column pass is never interleaved with AES beats.

---
 rtl/xor_unit_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter
// Shares one wide XOR unit between the AES requester and the SHA-3 requester.
// Operand bundles (4 lanes x 5 x 40 b) from the granted requester are driven
// onto xu_in; the combinational result xu_out is captured in a single output
// register and returned to the requester that owns it, tagged with its beat
// index inside the burst. Multi-beat bursts are locked so beats from the two
// requesters never interleave.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   aes_req_valid/ready/last/data   AES operand request channel
//   sha_req_valid/ready/last/data   SHA-3 operand request channel
//   xu_in  (out, DW)                operands to the XOR unit, zero when idle
//   xu_out (in,  RW)                XOR unit result, same cycle
//   aes_rsp_valid/ready             AES result channel
//   sha_rsp_valid/ready             SHA-3 result channel
//   rsp_data (RW), rsp_beat         shared registered result and beat index
//   busy                            burst in progress or result held
//
// Build option:
//   XOR_ARB_AES_PRIO_EN  when defined, idle arbitration is fixed priority
//                        (AES over SHA) and the round-robin pointer is removed.
//
// State  | meaning
// IDLE   | no burst open; arbitrate between valid requesters
// LOCK_AES | AES burst open; only AES may be granted
// LOCK_SHA | SHA-3 burst open; only SHA-3 may be granted

module xor_unit_arbiter #(
  parameter int DW     = 800,
  parameter int RW     = 160,
  parameter int BCNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aes_req_valid,
  output logic              aes_req_ready,
  input  logic              aes_req_last,
  input  logic [DW-1:0]     aes_req_data,
  input  logic              sha_req_valid,
  output logic              sha_req_ready,
  input  logic              sha_req_last,
  input  logic [DW-1:0]     sha_req_data,
  output logic [DW-1:0]     xu_in,
  input  logic [RW-1:0]     xu_out,
  output logic              aes_rsp_valid,
  input  logic              aes_rsp_ready,
  output logic              sha_rsp_valid,
  input  logic              sha_rsp_ready,
  output logic [RW-1:0]     rsp_data,
  output logic [BCNT_W-1:0] rsp_beat,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_AES = 2'd1,
    LOCK_SHA = 2'd2
  } state_t;

  localparam logic SRC_AES = 1'b0;
  localparam logic SRC_SHA = 1'b1;

  state_t            state, state_nxt;
  logic              grant_aes, grant_sha;
  logic              sha_first;
  logic              out_vld, out_src;
  logic [BCNT_W-1:0] beat_cnt;
  logic              pop, slot_free;
  logic              acc_aes, acc_sha, acc, acc_last;

`ifdef XOR_ARB_AES_PRIO_EN
  assign sha_first = 1'b0;
`else
  logic rr_ptr;
  assign sha_first = rr_ptr;
`endif

  // A held result leaves the register this cycle only if its owner takes it,
  // which lets a new beat be captured in the same cycle.
  assign pop       = out_vld & (out_src ? sha_rsp_ready : aes_rsp_ready);
  assign slot_free = !out_vld | pop;

  assign aes_req_ready = grant_aes & slot_free;
  assign sha_req_ready = grant_sha & slot_free;

  assign acc_aes  = aes_req_valid & aes_req_ready;
  assign acc_sha  = sha_req_valid & sha_req_ready;
  assign acc      = acc_aes | acc_sha;
  assign acc_last = acc_aes ? aes_req_last : sha_req_last;

  assign xu_in = grant_aes ? aes_req_data :
                 grant_sha ? sha_req_data : '0;

  assign aes_rsp_valid = out_vld & (out_src == SRC_AES);
  assign sha_rsp_valid = out_vld & (out_src == SRC_SHA);
  assign busy          = (state != IDLE) | out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and next state. In a locked state the owner keeps the grant even
  // with valid low, so the other requester cannot slip in mid-burst.
  always_comb begin
    grant_aes = 1'b0;
    grant_sha = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aes_req_valid && sha_req_valid) begin
          grant_sha = sha_first;
          grant_aes = !sha_first;
        end else begin
          grant_aes = aes_req_valid;
          grant_sha = sha_req_valid;
        end
      end
      LOCK_AES: grant_aes = 1'b1;
      LOCK_SHA: grant_sha = 1'b1;
      default:  state_nxt = IDLE;
    endcase
    if (acc) begin
      if (acc_last) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = acc_aes ? LOCK_AES : LOCK_SHA;
      end
    end
  end

`ifndef XOR_ARB_AES_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (acc && acc_last) begin
      rr_ptr <= acc_aes;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (acc) begin
      beat_cnt <= acc_last ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_src  <= SRC_AES;
      rsp_data <= '0;
      rsp_beat <= '0;
    end else if (acc) begin
      out_vld  <= 1'b1;
      out_src  <= acc_aes ? SRC_AES : SRC_SHA;
      rsp_data <= xu_out;
      rsp_beat <= beat_cnt;
    end else if (pop) begin
      out_vld <= 1'b0;
    end
  end

endmodule
